// File: rtl/dmem_result_monitor.sv
// dmem_result_monitor: data RAM for the single-cycle MIPS core.
// A sticky status FSM watches the same store stream and reports
// pass / fail / timeout in hardware.
module dmem_result_monitor #(
  parameter int unsigned DEPTH        = 64,
  parameter logic [31:0] PASS_ADDR    = 32'd84,
  parameter logic [31:0] PASS_DATA    = 32'd0,
  parameter logic [31:0] SCRATCH_ADDR = 32'd80,
  parameter int unsigned TIMEOUT      = 1000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] write_count,
  output logic [31:0]      fail_addr,
  output logic [31:0]      fail_data
);

  // DEPTH is assumed to be at least 2 so the word index has one or more bits.
  localparam int unsigned AW = $clog2(DEPTH);
  // The cycle counter must hold TIMEOUT itself: it still ticks on the timeout edge.
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST     = TW'(TIMEOUT - 1);
  localparam logic [32:0]   RAM_BYTES = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_PASS    = 2'd1,
    S_FAIL    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t           state_q;
  logic [TW-1:0]    cnt_q;
  logic [CNT_W-1:0] wc_q, wc_d;
  logic [31:0]      fa_q, fd_q;

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range, aligned, ram_we;

  assign idx      = dataadr[AW+1:2];
  assign in_range = ({1'b0, dataadr} < RAM_BYTES);
  assign aligned  = (dataadr[1:0] == 2'b00);
  // Stores are ignored while reset is held; the RAM itself is never cleared.
  assign ram_we   = reset & memwrite & aligned & in_range;

  // Data RAM write port, active in every FSM state.
  always_ff @(posedge clk) begin
    if (ram_we) mem[idx] <= writedata;
  end

  // Combinational load; out-of-range addresses read as zero.
  assign readdata = in_range ? mem[idx] : 32'd0;

  // Saturating store counter next value.
  always_comb begin
    wc_d = wc_q;
    if (wc_q != {CNT_W{1'b1}}) wc_d = wc_q + 1'b1;
  end

  // Status FSM: store evaluation takes priority over the timeout check,
  // except that a scratch store on the last cycle still times out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      wc_q    <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
    end else if (state_q == S_RUN) begin
      cnt_q <= cnt_q + 1'b1;
      if (memwrite) begin
        wc_q <= wc_d;
        if (dataadr == PASS_ADDR) begin
          if (writedata == PASS_DATA) begin
            state_q <= S_PASS;
          end else begin
            state_q <= S_FAIL;
            fa_q    <= dataadr;
            fd_q    <= writedata;
          end
        end else if (dataadr == SCRATCH_ADDR) begin
          if (cnt_q == TLAST) state_q <= S_TIMEOUT;
        end else begin
          state_q <= S_FAIL;
          fa_q    <= dataadr;
          fd_q    <= writedata;
        end
      end else if (cnt_q == TLAST) begin
        state_q <= S_TIMEOUT;
      end
    end
  end

  assign pass        = (state_q == S_PASS);
  assign fail        = (state_q == S_FAIL);
  assign timeout     = (state_q == S_TIMEOUT);
  assign done        = pass | fail | timeout;
  assign write_count = wc_q;
  assign fail_addr   = fa_q;
  assign fail_data   = fd_q;

endmodule

// File: tb/tb_dmem_result_monitor.sv
// Scoreboard bench for dmem_result_monitor: the stimulus process queues
// expected status/readdata snapshots, and the monitor compares them on
// the falling edge.
module tb_dmem_result_monitor;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          memwrite;
  logic [31:0]   dataadr, writedata, readdata;
  logic          done, pass, fail, timeout;
  logic [CW-1:0] write_count;
  logic [31:0]   fail_addr, fail_data;

  dmem_result_monitor #(
    .DEPTH(64), .PASS_ADDR(32'd84), .PASS_DATA(32'd0), .SCRATCH_ADDR(32'd80),
    .TIMEOUT(10), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .write_count(write_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  // {done, pass, fail, timeout}
  localparam logic [3:0] ST_RUN  = 4'b0000;
  localparam logic [3:0] ST_PASS = 4'b1100;
  localparam logic [3:0] ST_FAIL = 4'b1010;
  localparam logic [3:0] ST_TO   = 4'b1001;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [31:0] wc;
    logic [31:0] fa;
    logic [31:0] fd;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // Monitor: pop one expected snapshot per falling edge and compare.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      m_e = sb.pop_front();
      chk({m_e.name, ".status"}, {28'd0, done, pass, fail, timeout}, {28'd0, m_e.st});
      chk({m_e.name, ".wcount"}, 32'(write_count), m_e.wc);
      chk({m_e.name, ".faddr"},  fail_addr, m_e.fa);
      chk({m_e.name, ".fdata"},  fail_data, m_e.fd);
      chk({m_e.name, ".rdata"},  readdata,  m_e.rd);
    end
  end

  // Tasks start and end at posedge+1.
  task automatic do_reset();
    reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a load address and queue the snapshot expected at the next falling edge.
  task automatic expect_st(input string n, input logic [31:0] ra, input logic [3:0] st,
                           input logic [31:0] wc, input logic [31:0] fa,
                           input logic [31:0] fd, input logic [31:0] rd);
    exp_t e;
    memwrite = 1'b0; dataadr = ra;
    e.name = n; e.st = st; e.wc = wc; e.fa = fa; e.fd = fd; e.rd = rd;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;

    // Reset state and the pass flow
    do_reset();
    expect_st("reset", 32'd256, ST_RUN, 0, 0, 0, 0);
    do_reset();
    store(32'd80, 32'd7);
    expect_st("scratch", 32'd80, ST_RUN, 1, 0, 0, 32'd7);
    store(32'd84, 32'd0);
    expect_st("pass", 32'd84, ST_PASS, 2, 0, 0, 32'd0);
    expect_st("pass_ram20", 32'd80, ST_PASS, 2, 0, 0, 32'd7);

    // Wrong pass data, then a late correct store is ignored by the FSM
    do_reset();
    store(32'd84, 32'd5);
    expect_st("wrong_data", 32'd84, ST_FAIL, 1, 32'd84, 32'd5, 32'd5);
    store(32'd84, 32'd0);
    expect_st("fail_sticky", 32'd84, ST_FAIL, 1, 32'd84, 32'd5, 32'd0);

    // Illegal address, then misaligned store
    do_reset();
    store(32'd88, 32'h1234);
    expect_st("illegal_addr", 32'd88, ST_FAIL, 1, 32'd88, 32'h1234, 32'h1234);
    do_reset();
    store(32'd81, 32'hdead);
    expect_st("misaligned", 32'd80, ST_FAIL, 1, 32'd81, 32'hdead, 32'd7);

    // Timeout on the 10th edge after release
    do_reset();
    idle(9);
    expect_st("pre_timeout", 32'd84, ST_RUN, 0, 0, 0, 32'd0);
    expect_st("timeout", 32'd84, ST_TO, 0, 0, 0, 32'd0);
    // Pass store on the timeout edge wins
    do_reset();
    idle(9);
    store(32'd84, 32'd0);
    expect_st("pass_on_to_edge", 32'd84, ST_PASS, 1, 0, 0, 32'd0);
    // Scratch store on the timeout edge still times out
    do_reset();
    idle(9);
    store(32'd80, 32'd3);
    expect_st("scratch_on_to_edge", 32'd80, ST_TO, 1, 0, 0, 32'd3);

    // Mid-test reset: status clears at once, RAM kept, stores ignored
    do_reset();
    store(32'd80, 32'h55);
    store(32'd84, 32'd0);
    expect_st("pre_mid_rst", 32'd80, ST_PASS, 2, 0, 0, 32'h55);
    reset = 1'b0;
    expect_st("mid_rst", 32'd80, ST_RUN, 0, 0, 0, 32'h55);
    store(32'd80, 32'h99);
    expect_st("store_in_rst", 32'd80, ST_RUN, 0, 0, 0, 32'h55);

    // Out-of-range: load reads 0, store fails and must not alias word 0
    do_reset();
    store(32'd0, 32'h11);
    expect_st("word0_store", 32'd0, ST_FAIL, 1, 32'd0, 32'h11, 32'h11);
    do_reset();
    expect_st("oor_load", 32'd256, ST_RUN, 0, 0, 0, 32'd0);
    store(32'd256, 32'habc);
    expect_st("oor_store", 32'd0, ST_FAIL, 1, 32'd256, 32'habc, 32'h11);

    // write_count saturates at all-ones (CNT_W=3)
    do_reset();
    for (int i = 1; i <= 8; i++) store(32'd80, 32'(i));
    expect_st("wc_saturate", 32'd80, ST_RUN, 7, 0, 0, 32'd8);

    @(posedge clk); #1;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
